// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the memory port arbiter.
//   - DEF_ADDR_W / DEF_DATA_W : default address and data widths.
//   - arbState_t              : arbiter FSM state encoding.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_BUSY = 2'd1,
    IF_BUSY  = 2'd2
  } arbState_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported external memory between instruction fetch (IF)
//   and the MEM-stage load/store. MEM (the older instruction) wins over IF,
//   and an in-flight transfer always runs to completion. Stall outputs freeze
//   the pipeline registers until the access that blocks them has finished.
//
//   Ports:
//     clk, rst_n          : clock, synchronous active-low reset
//     ifReq, ifAddr       : fetch request and PC
//     ifRdata, ifValid    : fetched instruction, held until IF/ID takes it
//     memRead, memWrite   : load/store controls from EX/MEM
//     memAddr, memWdata   : load/store address and store data
//     memRdata, memDone   : load data and one-cycle completion pulse
//     stallMEM, stallIF   : freeze EX/MEM+upstream / freeze PC and IF/ID
//     extReq, extWe       : external request and write enable
//     extAddr, extWdata   : external address and write data
//     extRdata, extReady  : external read data and transfer-complete flag
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [DATA_W-1:0] ifRdata,
  output logic              ifValid,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] memWdata,
  output logic [DATA_W-1:0] memRdata,
  output logic              memDone,
  output logic              stallMEM,
  output logic              stallIF,
  output logic              extReq,
  output logic              extWe,
  output logic [ADDR_W-1:0] extAddr,
  output logic [DATA_W-1:0] extWdata,
  input  logic [DATA_W-1:0] extRdata,
  input  logic              extReady
);

  arbState_t         state, stateNext;
  logic              extReqNext, extWeNext, memDoneNext, ifValidNext;
  logic [ADDR_W-1:0] extAddrNext;
  logic [DATA_W-1:0] extWdataNext, ifRdataNext, memRdataNext;
  logic              memPend, xferDone;

  // The memDone term keeps a finished access from being reissued while the
  // same instruction still sits in EX/MEM during the completion cycle.
  assign memPend  = (memRead | memWrite) & ~memDone;
  assign stallMEM = memPend;
  assign stallIF  = stallMEM | (ifReq & ~ifValid);
  assign xferDone = extReq & extReady;

  always_comb begin
    stateNext    = state;
    extReqNext   = extReq;
    extWeNext    = extWe;
    extAddrNext  = extAddr;
    extWdataNext = extWdata;
    ifRdataNext  = ifRdata;
    memRdataNext = memRdata;
    memDoneNext  = 1'b0;
    // A held instruction is consumed on the first edge with stallIF low.
    ifValidNext  = ifValid & stallIF;

    case (state)
      IDLE: begin
        if (memPend) begin
          extReqNext   = 1'b1;
          extWeNext    = memWrite;
          extAddrNext  = memAddr;
          extWdataNext = memWdata;
          stateNext    = MEM_BUSY;
        end else if (ifReq && !ifValid) begin
          extReqNext  = 1'b1;
          extWeNext   = 1'b0;
          extAddrNext = ifAddr;
          stateNext   = IF_BUSY;
        end else begin
          extReqNext = 1'b0;
        end
      end
      MEM_BUSY: begin
        if (xferDone) begin
          extReqNext  = 1'b0;
          memDoneNext = 1'b1;
          stateNext   = IDLE;
          if (!extWe) memRdataNext = extRdata;
        end
      end
      IF_BUSY: begin
        if (xferDone) begin
          extReqNext  = 1'b0;
          ifRdataNext = extRdata;
          ifValidNext = 1'b1;
          stateNext   = IDLE;
        end
      end
      default: begin
        extReqNext = 1'b0;
        stateNext  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      extReq   <= 1'b0;
      extWe    <= 1'b0;
      extAddr  <= '0;
      extWdata <= '0;
      ifRdata  <= '0;
      ifValid  <= 1'b0;
      memRdata <= '0;
      memDone  <= 1'b0;
    end else begin
      state    <= stateNext;
      extReq   <= extReqNext;
      extWe    <= extWeNext;
      extAddr  <= extAddrNext;
      extWdata <= extWdataNext;
      ifRdata  <= ifRdataNext;
      ifValid  <= ifValidNext;
      memRdata <= memRdataNext;
      memDone  <= memDoneNext;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported external memory between instruction fetch (IF) and the MEM-stage load/store carried by the EX/MEM pipeline register.
- Sequences multi-cycle memory transactions and generates the stall signals that freeze the PC, IF/ID, ID/EX and EX/MEM registers until each access completes.
- MEM (older instruction) has priority over IF. An in-flight transaction is never preempted.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst_n  in  1  synchronous reset, active-low
- ifReq  in  1  fetch wanted for ifAddr this cycle
- ifAddr  in  ADDR_W  fetch address (PC)
- ifRdata  out  DATA_W  fetched instruction; valid while ifValid=1
- ifValid  out  1  fetched instruction held and ready for the IF/ID register
- memRead  in  1  memReadMEM from EX/MEM
- memWrite  in  1  memWriteMEM from EX/MEM
- memAddr  in  ADDR_W  aluResultMEM
- memWdata  in  DATA_W  regReadData2MEM
- memRdata  out  DATA_W  load data toward MEM/WB; valid while memDone=1
- memDone  out  1  one-cycle pulse: MEM access complete
- stallMEM  out  1  freeze EX/MEM and all upstream registers
- stallIF  out  1  freeze PC and IF/ID
- extReq  out  1  external memory request
- extWe  out  1  write enable for the current request
- extAddr  out  ADDR_W  request address
- extWdata  out  DATA_W  request write data
- extRdata  in  DATA_W  read data, valid when extReady=1
- extReady  in  1  transfer completes on the edge where extReq=1 and extReady=1

Behaviour:
- FSM states: IDLE, MEM_BUSY, IF_BUSY. All control outputs are registered.
- memPend = (memRead | memWrite) & ~memDone.
- IDLE transitions:
  - If memPend: capture memAddr, memWdata and memWrite into extAddr, extWdata and extWe; set extReq=1; go to MEM_BUSY.
  - Else if ifReq & ~ifValid: capture ifAddr; set extWe=0, extReq=1; go to IF_BUSY.
  - Else stay in IDLE with extReq=0.
- BUSY states:
  - extReq, extAddr, extWdata and extWe are held stable until extReady=1.
  - On the completing edge: extReq<=0 and state<=IDLE.
  - MEM_BUSY completion: memRdata<=extRdata (reads only; writes leave memRdata unchanged) and memDone<=1 for exactly one cycle.
  - IF_BUSY completion: ifRdata<=extRdata and ifValid<=1.
- ifValid clears on the first edge where stallIF=0, i.e. the instruction is consumed by IF/ID. A new fetch is never started while ifValid=1.
- Combinational stall outputs:
  - stallMEM = memPend.
  - stallIF = stallMEM | (ifReq & ~ifValid).
- Latency with a zero-wait memory (extReady held at 1): a request first seen in IDLE in cycle t gives extReq in cycle t+1 and done/valid in cycle t+2.
- Simultaneous events:
  - memPend and ifReq both in IDLE: MEM wins; IF waits.
  - memDone cycle: the same MEM instruction is not reissued, and IF may issue in that cycle.
- An IF completion while stallMEM=1 keeps ifRdata and ifValid held until consumption.
- Reset (rst_n=0 at an edge):
  - State returns to IDLE.
  - extReq, extWe, memDone and ifValid go to 0.
  - extAddr, extWdata, ifRdata and memRdata go to 0.
  - An in-flight request is abandoned; the external memory must tolerate extReq dropping without extReady.

Decomposition:
- Shared package holds the state encoding (2-bit enum IDLE=0, MEM_BUSY=1, IF_BUSY=2) and the ADDR_W/DATA_W defaults.
- No sub-module: the FSM and its capture registers form one block.

Test Plan:
- Zero-wait memory, ifReq=1 at ifAddr=0x0040, extRdata=0x2002000A:
  - extReq in cycle t+1 with extAddr=0x0040 and extWe=0.
  - ifValid=1 and ifRdata=0x2002000A in cycle t+2.
  - stallIF=1 in cycles t and t+1, 0 in cycle t+2.
- Load with memRead=1, memAddr=0x100 and memory ready after 3 wait cycles, returning 0xDEADBEEF:
  - stallMEM high until memDone.
  - memDone high for exactly one cycle with memRdata=0xDEADBEEF.
  - No reissue in the memDone cycle.
- Store and fetch together: memWrite=1, memAddr=0x200, memWdata=0x12345678, ifReq=1 in the same IDLE cycle:
  - Store issues first with extWe=1 and extWdata=0x12345678.
  - Fetch issues in the memDone cycle.
- IF in flight (2 wait states) when memRead rises:
  - IF completes uninterrupted.
  - ifValid stays 1 through the following MEM access and clears on the first cycle with stallIF=0.
- Reset mid-operation: rst_n=0 during MEM_BUSY:
  - Next cycle: state=IDLE with extReq=0, memDone=0 and ifValid=0.
  - After release with memRead=1 still asserted, the access restarts from IDLE.
